// File: rtl/imem_loader.sv
// Boot-time instruction loader: framed byte stream -> 32-bit imem words.
// Holds the core in reset until a checksum-verified image is resident.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   load_start    pulse to begin a load (honoured in IDLE/DONE/ERROR)
//   byte_valid    upstream byte present
//   byte_data     upstream byte
//   byte_ready    loader accepts a byte this cycle (registered)
//   imem_we       one-cycle write pulse per assembled word
//   imem_addr     byte address of the written word (word_idx*4)
//   imem_wdata    assembled little-endian word {b3,b2,b1,b0}
//   cpu_rst       core reset, low only in DONE
//   busy          high in LEN_LO, LEN_HI, DATA, CHECK
//   done          high in DONE
//   error         high in ERROR
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           r_state;
    logic [7:0]       r_len_lo;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_word_idx;
    logic [1:0]       r_byte_idx;
    logic [23:0]      r_lanes;
    logic [7:0]       r_chk;

    logic             r_byte_ready;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_cpu_rst;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    state_t           w_next;
    logic             w_accept;
    logic             w_start;
    logic [CNT_W-1:0] w_len;
    logic             w_len_bad;
    logic             w_last_byte;
    logic             w_last_word;
    logic             w_next_busy;

    assign w_accept    = byte_valid && r_byte_ready;
    assign w_start     = load_start &&
                         ((r_state == S_IDLE) ||
                          (r_state == S_DONE) ||
                          (r_state == S_ERROR));
    assign w_len       = CNT_W'({byte_data, r_len_lo});
    assign w_len_bad   = (w_len == '0) ||
                         (w_len > CNT_W'(DEPTH_WORDS));
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = (r_word_idx == r_len - CNT_W'(1));
    assign w_next_busy = (w_next == S_LEN_LO) ||
                         (w_next == S_LEN_HI) ||
                         (w_next == S_DATA)   ||
                         (w_next == S_CHECK);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept)
                    w_next = w_len_bad ? S_ERROR : S_DATA;
            end
            S_DATA: begin
                if (w_accept && w_last_byte && w_last_word)
                    w_next = S_CHECK;
            end
            S_CHECK: begin
                // r_chk already holds the XOR of every payload byte
                if (w_accept)
                    w_next = (r_chk == byte_data) ? S_DONE : S_ERROR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len_lo     <= '0;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_lanes      <= '0;
            r_chk        <= '0;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            // Status flags are derived from the next state so they
            // line up with the state register
            r_byte_ready <= w_next_busy;
            r_busy       <= w_next_busy;
            r_done       <= (w_next == S_DONE);
            r_error      <= (w_next == S_ERROR);
            r_cpu_rst    <= (w_next != S_DONE);
            r_we         <= 1'b0;

            if (w_start) begin
                r_len_lo   <= '0;
                r_len      <= '0;
                r_word_idx <= '0;
                r_byte_idx <= '0;
                r_lanes    <= '0;
                r_chk      <= '0;
            end

            if (r_state == S_LEN_LO && w_accept)
                r_len_lo <= byte_data;

            if (r_state == S_LEN_HI && w_accept)
                r_len <= w_len;

            if (r_state == S_DATA && w_accept) begin
                r_chk      <= r_chk ^ byte_data;
                r_byte_idx <= r_byte_idx + 2'd1;
                unique case (r_byte_idx)
                    2'd0: r_lanes[7:0]   <= byte_data;
                    2'd1: r_lanes[15:8]  <= byte_data;
                    2'd2: r_lanes[23:16] <= byte_data;
                    default: begin
                        // Fourth byte completes the word: write it
                        // next cycle while still accepting bytes
                        r_we       <= 1'b1;
                        r_addr     <= 32'({r_word_idx, 2'b00});
                        r_wdata    <= {byte_data, r_lanes};
                        r_word_idx <= r_word_idx + CNT_W'(1);
                    end
                endcase
            end
        end
    end

    assign byte_ready = r_byte_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a frame-level model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  pay[$];
    logic [63:0] got[$];
    logic [63:0] exp_w[$];

    imem_loader #(.DEPTH_WORDS(256), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (imem_we === 1'b1) got.push_back({imem_addr, imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int gap_of(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        forever begin
            rdy = byte_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $error("FAIL ready_timeout observed=0 expected=1");
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        // byte_valid alongside load_start must not be taken
        @(negedge clk);
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        @(negedge clk);
        load_start = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic fill_random(input int nwords);
        pay.delete();
        for (int i = 0; i < 4 * nwords; i++)
            pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_frame(input int len, input logic [7:0] delta,
                             input int mode, input int ls_at,
                             input bit do_start, input string tag);
        logic [15:0] l16;
        logic [7:0]  x;
        logic [7:0]  chk;
        bit          ok_len;
        bit          good;
        l16    = 16'(len);
        x      = 8'h00;
        ok_len = (len != 0) && (len <= 256);
        exp_w.delete();
        if (ok_len) begin
            for (int w = 0; w < len; w++)
                exp_w.push_back({32'(w * 4), pay[4*w+3], pay[4*w+2],
                                 pay[4*w+1], pay[4*w]});
            foreach (pay[i]) x ^= pay[i];
        end
        chk  = x ^ delta;
        good = ok_len && (delta == 8'h00);
        if (do_start) pulse_start();
        got.delete();
        send_byte(l16[7:0], gap_of(mode));
        send_byte(l16[15:8], gap_of(mode));
        if (!ok_len) begin
            #1;
            check({tag, "_lenerr"}, error, 1);
            check({tag, "_lenbusy"}, busy, 0);
            check({tag, "_lenrdy"}, byte_ready, 0);
        end else begin
            for (int i = 0; i < pay.size(); i++) begin
                if (i == ls_at) begin
                    @(negedge clk);
                    byte_valid = 1'b0;
                    load_start = 1'b1;
                    @(negedge clk);
                    load_start = 1'b0;
                    check({tag, "_lsbusy"}, busy, 1);
                end
                send_byte(pay[i], gap_of(mode));
            end
            #1;
            check({tag, "_prechk_rst"}, cpu_rst, 1);
            send_byte(chk, gap_of(mode));
            #1;
            check({tag, "_done"}, done, good);
            check({tag, "_error"}, error, !good);
            check({tag, "_cpurst"}, cpu_rst, !good);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_nwr"}, got.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < got.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), got[i], exp_w[i]);
        check({tag, "_cpurst_hold"}, cpu_rst, !good);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", byte_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_cpurst", cpu_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        rst = 1'b0;

        pay = '{8'h13, 8'h05, 8'hA0, 8'h02};
        run_frame(1, 8'h00, 0, -1, 1'b1, "one_word");
        check("one_word_lit", exp_w[0][31:0], 32'h02A00513);

        fill_random(3);
        run_frame(3, 8'h00, 1, -1, 1'b1, "stall3");

        pay.delete();
        run_frame(0, 8'h00, 0, -1, 1'b1, "len0");
        run_frame(257, 8'h00, 0, -1, 1'b1, "len257");

        fill_random(2);
        run_frame(2, 8'h01, 0, -1, 1'b1, "badchk");
        fill_random(2);
        run_frame(2, 8'h00, 2, -1, 1'b1, "retry");

        fill_random(4);
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 0);
        @(negedge clk);
        byte_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ready", byte_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cpurst", cpu_rst, 1);
        check("mid_rst_addr", imem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        fill_random(2);
        run_frame(2, 8'h00, 0, -1, 1'b1, "post_rst");

        fill_random(3);
        run_frame(3, 8'h00, 0, 6, 1'b1, "ls_data");

        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        check("done_ls_cpurst", cpu_rst, 1);
        check("done_ls_busy", busy, 1);
        check("done_ls_ready", byte_ready, 1);
        check("done_ls_done", done, 0);
        @(negedge clk);
        load_start = 1'b0;
        fill_random(1);
        run_frame(1, 8'h00, 0, -1, 1'b0, "after_done");

        for (int k = 0; k < 6; k++) begin
            int          n;
            logic [7:0]  d;
            n = int'($urandom_range(1, 6));
            d = ($urandom_range(0, 3) == 0) ?
                8'($urandom_range(1, 255)) : 8'h00;
            fill_random(n);
            run_frame(n, d, 2, -1, 1'b1, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time instruction loader that sits directly upstream of the single-cycle RV32 core's instruction memory. It receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit words. It writes those words into instruction memory through a dedicated write port, and holds the core in reset until a complete, checksum-verified image is resident. On success it releases the core, which then starts fetching from PC = 0.

Parameters:
DEPTH_WORDS, 256, instruction memory capacity in 32-bit words; the maximum legal image length
CNT_W, 16, width of the length header field (bytes LEN_LO and LEN_HI)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-high reset
load_start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR
byte_valid  input  1  upstream byte is present
byte_data  input  8  upstream byte
byte_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction memory write enable, one-cycle pulse per word
imem_addr  output  32  byte address of the word being written; word aligned, equal to word_idx*4
imem_wdata  output  32  assembled word {b3,b2,b1,b0}
cpu_rst  output  1  reset to the core; high whenever state != DONE
busy  output  1  high in LEN_LO, LEN_HI, DATA and CHECK
done  output  1  high in DONE
error  output  1  high in ERROR

Behaviour:
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, error=0. Word and byte counters and the checksum accumulator are cleared.
- rst overrides everything. Reset mid-load returns to IDLE; words already written are not undone.
- A byte is accepted only on a rising edge where byte_valid && byte_ready. byte_ready is a registered output, high exactly in LEN_LO, LEN_HI, DATA and CHECK.
- Frame format, in order: LEN_LO, LEN_HI, then 4*N payload bytes (little-endian per word), then one CHK byte. N = {LEN_HI, LEN_LO}. CHK must equal the XOR of all payload bytes; header bytes are excluded from the checksum.
- State transitions:
  - IDLE: on load_start, go to LEN_LO; clear counters and checksum.
  - LEN_LO: on accept, latch the low byte and go to LEN_HI.
  - LEN_HI: on accept, form N. If N==0 or N>DEPTH_WORDS, go to ERROR; otherwise go to DATA.
  - DATA: each accepted byte is stored in lane byte_idx and XORed into the checksum; byte_idx increments modulo 4. On the 4th byte, the next cycle shows imem_we=1, imem_addr=word_idx*4, imem_wdata=assembled word, and word_idx then increments. byte_ready stays 1 during the write cycle, so there is no bubble. After word N-1 is accepted, go to CHECK.
  - CHECK: on accept, if the checksum (including the final payload byte) equals CHK, go to DONE; otherwise go to ERROR.
  - DONE: cpu_rst=0 starting the cycle after CHK is accepted. On load_start, go to LEN_LO and re-assert cpu_rst=1 from the next cycle.
  - ERROR: cpu_rst stays 1. On load_start, retry by going to LEN_LO.
- load_start is ignored while busy=1.
- A byte_valid that arrives together with load_start in IDLE is not accepted, because byte_ready is 0 that cycle.
- imem_we is never asserted outside DATA-originated writes. imem_addr and imem_wdata hold their last values when imem_we=0.
- imem_addr wrap-around is impossible, because N ≤ DEPTH_WORDS.

Test Plan:
- Reset, then load_start; send 01 00 13 05 A0 02 CHK=0xB4 with no stalls. Required: a single imem_we pulse with addr=0x0 and wdata=0x02A00513; done=1; cpu_rst falls one cycle after CHK is accepted.
- N=3 words with byte_valid toggled every other cycle. Required: three imem_we pulses at addr 0x0, 0x4 and 0x8 with the correct words, and none while stalled.
- Send LEN=0x0000, and separately LEN=0x0101 with DEPTH_WORDS=256. Required: ERROR immediately after LEN_HI, no imem_we pulse, cpu_rst=1.
- Send a valid 2-word image with CHK off by 0x01. Required: both words written, then error=1, done=0, cpu_rst held at 1. A following load_start plus a correct image must reach DONE.
- Assert rst after 5 payload bytes of a 4-word image. Required: next cycle IDLE, byte_ready=0, all counters 0. A fresh load must write from addr 0x0.
- Pulse load_start while in DATA. Required: it is ignored and word_idx is unchanged. Pulse load_start in DONE. Required: cpu_rst=1 next cycle, state LEN_LO.
